draw_rect_fall_ctl: RTL and testbench

//  Parametrised successor to the rectangle position controller. Sits between the mouse

---
 rtl/draw_rect_fall_ctl.sv | 149 ++++++++++++++
 tb/tb_draw_rect_fall_ctl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/draw_rect_fall_ctl.sv
// Rectangle position controller: the rectangle follows the mouse until a left
// click releases it; it then falls under constant gravity, bounces off the
// floor with damping and finally rests there. Any further click hands control
// back to the mouse.
module draw_rect_fall_ctl #(
    parameter int POS_WIDTH  = 12,
    parameter int VEL_WIDTH  = 10,
    parameter int SCREEN_H   = 600,
    parameter int RECT_H     = 48,
    parameter int TICK_DIV   = 666_667,
    parameter int GRAVITY    = 1,
    parameter int DAMP_SHIFT = 1,
    parameter int V_MIN      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mouse_left,
    input  logic [POS_WIDTH-1:0] mouse_xpos,
    input  logic [POS_WIDTH-1:0] mouse_ypos,
    output logic [POS_WIDTH-1:0] xpos,
    output logic [POS_WIDTH-1:0] ypos,
    output logic                 busy,
    output logic                 at_rest
);

    localparam int FLOOR = SCREEN_H - RECT_H;
    localparam int SW    = POS_WIDTH + 1;            // ysum width, cannot overflow
    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [POS_WIDTH-1:0] FLOOR_P   = POS_WIDTH'(FLOOR);
    localparam logic [SW-1:0]        FLOOR_S   = SW'(FLOOR);
    localparam logic [VEL_WIDTH-1:0] GRAV_V    = VEL_WIDTH'(GRAVITY);
    localparam logic [VEL_WIDTH:0]   GRAV_X    = (VEL_WIDTH+1)'(GRAVITY);
    localparam logic [VEL_WIDTH-1:0] VMIN_V    = VEL_WIDTH'(V_MIN);
    localparam logic [VEL_WIDTH-1:0] VEL_MAX   = '1;
    localparam logic [CNT_W-1:0]     TICK_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, FALL, RISE, REST} state_t;

    state_t                 state_q;
    logic                   left_q;
    logic [CNT_W-1:0]       tick_cnt_q, tick_cnt_d;
    logic [VEL_WIDTH-1:0]   vel_q;
    logic [POS_WIDTH-1:0]   xpos_q, ypos_q;
    logic                   busy_q, at_rest_q;

    logic                   click, tick;
    logic [POS_WIDTH-1:0]   ypos_clamp;
    logic [SW-1:0]          ysum, vel_ext;
    logic [VEL_WIDTH:0]     vel_inc;
    logic [VEL_WIDTH-1:0]   vel_sat, vb;

    assign xpos    = xpos_q;
    assign ypos    = ypos_q;
    assign busy    = busy_q;
    assign at_rest = at_rest_q;

    // Edge detect, physics tick and the per-tick arithmetic shared by FALL/RISE.
    always_comb begin
        click      = mouse_left & ~left_q;
        tick       = (tick_cnt_q == TICK_LAST);
        ypos_clamp = (mouse_ypos > FLOOR_P) ? FLOOR_P : mouse_ypos;
        vel_ext    = SW'(vel_q);
        ysum       = {1'b0, ypos_q} + vel_ext;
        vel_inc    = {1'b0, vel_q} + GRAV_X;
        vel_sat    = vel_inc[VEL_WIDTH] ? VEL_MAX : vel_inc[VEL_WIDTH-1:0];
        vb         = vel_q - (vel_q >> DAMP_SHIFT);
        // The tick phase restarts at release so the first physics step is a full period away.
        if (state_q == IDLE && click) tick_cnt_d = '0;
        else if (tick)                tick_cnt_d = '0;
        else                          tick_cnt_d = tick_cnt_q + CNT_W'(1);
    end

    // Motion FSM; position, velocity and status flags are all updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            left_q     <= 1'b0;
            tick_cnt_q <= '0;
            vel_q      <= '0;
            xpos_q     <= '0;
            ypos_q     <= '0;
            busy_q     <= 1'b0;
            at_rest_q  <= 1'b0;
        end else begin
            left_q     <= mouse_left;
            tick_cnt_q <= tick_cnt_d;
            if (state_q != IDLE && click) begin
                // A click always wins over a coincident tick.
                state_q   <= IDLE;
                vel_q     <= '0;
                busy_q    <= 1'b0;
                at_rest_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (click) begin
                            state_q <= FALL;
                            vel_q   <= '0;
                            busy_q  <= 1'b1;
                        end else begin
                            xpos_q <= mouse_xpos;
                            ypos_q <= ypos_clamp;
                        end
                    end
                    FALL: begin
                        if (tick) begin
                            if (ysum < FLOOR_S) begin
                                ypos_q <= ysum[POS_WIDTH-1:0];
                                vel_q  <= vel_sat;
                            end else begin
                                ypos_q <= FLOOR_P;
                                if (vb < VMIN_V) begin
                                    state_q   <= REST;
                                    vel_q     <= '0;
                                    at_rest_q <= 1'b1;
                                end else begin
                                    state_q <= RISE;
                                    vel_q   <= vb;
                                end
                            end
                        end
                    end
                    RISE: begin
                        if (tick) begin
                            if (vel_q <= GRAV_V) begin
                                state_q <= FALL;
                                vel_q   <= '0;
                            end else if (vel_ext > {1'b0, ypos_q}) begin
                                // Would overshoot the top edge: pin to the ceiling and drop.
                                state_q <= FALL;
                                vel_q   <= '0;
                                ypos_q  <= '0;
                            end else begin
                                ypos_q <= ypos_q - POS_WIDTH'(vel_q);
                                vel_q  <= vel_q - GRAV_V;
                            end
                        end
                    end
                    default: begin
                        // REST: hold on the floor until the next click.
                        ypos_q <= FLOOR_P;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_draw_rect_fall_ctl.sv
// Bench for draw_rect_fall_ctl: a vector table for reset/tracking/release,
// hand-written sequences for bounce, restart and held-button/reset cases, and
// randomized drops checked against a tick-level trajectory model.
module tb_draw_rect_fall_ctl;
    localparam int PW    = 12;
    localparam int FLOOR = 552;
    localparam int G     = 1;
    localparam int DS    = 1;
    localparam int VMIN  = 2;
    localparam int VMAX  = 1023;
    localparam int TDIV  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mouse_left = 1'b0;
    logic [PW-1:0] mouse_xpos = '0;
    logic [PW-1:0] mouse_ypos = '0;
    logic [PW-1:0] xpos, ypos;
    logic          busy, at_rest;

    int total = 0;
    int bad   = 0;
    int tq[$];   // expected ypos after each tick
    int rq[$];   // expected at_rest after each tick

    typedef struct {
        bit r; bit l; int mx; int my;
        int ex; int ey; bit eb; bit er;
    } vec_t;
    vec_t vecs[16];

    draw_rect_fall_ctl #(
        .POS_WIDTH(PW), .VEL_WIDTH(10), .SCREEN_H(600), .RECT_H(48),
        .TICK_DIV(TDIV), .GRAVITY(G), .DAMP_SHIFT(DS), .V_MIN(VMIN)
    ) dut (
        .clk(clk), .rst(rst), .mouse_left(mouse_left),
        .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .xpos(xpos), .ypos(ypos), .busy(busy), .at_rest(at_rest)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Trajectory of a released rectangle, one entry per physics tick.
    task automatic build_traj(input int y0);
        int y, v;
        bit up;
        y = y0; v = 0; up = 0;
        tq.delete(); rq.delete();
        for (int k = 0; k < 2000; k++) begin
            if (!up) begin
                if (y + v < FLOOR) begin
                    y = y + v;
                    v = (v + G > VMAX) ? VMAX : v + G;
                end else begin
                    y = FLOOR;
                    v = v - (v / (1 << DS));
                    if (v < VMIN) begin
                        tq.push_back(y); rq.push_back(1);
                        return;
                    end
                    up = 1;
                end
            end else begin
                if (v <= G)     begin v = 0; up = 0; end
                else if (v > y) begin y = 0; v = 0; up = 0; end
                else            begin y = y - v; v = v - G; end
            end
            tq.push_back(y); rq.push_back(0);
        end
    endtask

    task automatic track(input int mx, input int my);
        mouse_left = 1'b0; mouse_xpos = PW'(mx); mouse_ypos = PW'(my);
        step(); step();
        check("track_x", xpos, mx);
        check("track_y", ypos, (my > FLOOR) ? FLOOR : my);
    endtask

    // Release from (mx,my), follow every tick to rest, then click back to IDLE.
    task automatic run_fall(input int mx, input int my, input bit wiggle);
        int y0, maxy;
        y0 = (my > FLOOR) ? FLOOR : my;
        track(mx, my);
        build_traj(y0);
        mouse_left = 1'b1; step();
        check("click_busy", busy, 1);
        check("click_y", ypos, y0);
        mouse_left = 1'b0;
        maxy = 0;
        for (int k = 0; k < tq.size(); k++) begin
            for (int c = 0; c < TDIV; c++) begin
                if (wiggle) begin
                    mouse_xpos = PW'($urandom_range(0, 799));
                    mouse_ypos = PW'($urandom_range(0, 700));
                end
                step();
            end
            check("tick_y", ypos, tq[k]);
            check("tick_x_frozen", xpos, mx);
            check("tick_busy", busy, 1);
            check("tick_rest", at_rest, rq[k]);
            if (int'(ypos) > maxy) maxy = int'(ypos);
        end
        check("max_y_le_floor", maxy <= FLOOR, 1);
        repeat (3 * TDIV) step();
        check("rest_y", ypos, FLOOR);
        check("rest_flag", at_rest, 1);
        mouse_left = 1'b1; step();
        check("exit_busy", busy, 0);
        check("exit_rest", at_rest, 0);
        mouse_left = 1'b0; step();
    endtask

    initial begin
        int kr, nb;

        // rst, left, mx, my, exp x, exp y, busy, at_rest
        vecs[0]  = '{1, 0,  15,  15,   0,   0, 0, 0};
        vecs[1]  = '{0, 0,  15,  15,  15,  15, 0, 0};
        vecs[2]  = '{0, 0,  15, 590,  15, 552, 0, 0};
        vecs[3]  = '{0, 0,  15,  15,  15,  15, 0, 0};
        vecs[4]  = '{0, 1,  15,  15,  15,  15, 1, 0};
        vecs[5]  = '{0, 1, 200, 300,  15,  15, 1, 0};
        vecs[6]  = '{0, 1, 200, 300,  15,  15, 1, 0};
        vecs[7]  = '{0, 1, 200, 300,  15,  15, 1, 0};
        vecs[8]  = '{0, 1, 200, 300,  15,  15, 1, 0};
        vecs[9]  = '{0, 1, 200, 300,  15,  15, 1, 0};
        vecs[10] = '{0, 1, 200, 300,  15,  15, 1, 0};
        vecs[11] = '{0, 1, 200, 300,  15,  15, 1, 0};
        vecs[12] = '{0, 1, 200, 300,  15,  16, 1, 0};
        vecs[13] = '{0, 0, 200, 300,  15,  16, 1, 0};
        vecs[14] = '{0, 1, 200, 300,  15,  16, 0, 0};
        vecs[15] = '{0, 1,  40,  50,  40,  50, 0, 0};

        for (int i = 0; i < 16; i++) begin
            rst = vecs[i].r; mouse_left = vecs[i].l;
            mouse_xpos = PW'(vecs[i].mx); mouse_ypos = PW'(vecs[i].my);
            step();
            check($sformatf("vec%0d_x", i), xpos, vecs[i].ex);
            check($sformatf("vec%0d_y", i), ypos, vecs[i].ey);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].eb);
            check($sformatf("vec%0d_rest", i), at_rest, vecs[i].er);
        end
        mouse_left = 1'b0; step();

        // Full drop from (15,15) through every bounce to rest.
        run_fall(15, 15, 0);

        // Click during RISE on the very cycle of a tick.
        track(15, 15);
        build_traj(15);
        kr = -1;
        for (int k = 1; k < tq.size(); k++)
            if (kr < 0 && tq[k] < tq[k-1]) kr = k;
        check("rise_found", kr > 0, 1);
        mouse_left = 1'b1; step();
        mouse_left = 1'b0;
        for (int k = 0; k < kr; k++) begin
            repeat (TDIV) step();
            check("pre_rise_y", ypos, tq[k]);
        end
        repeat (TDIV - 1) step();
        mouse_left = 1'b1; mouse_xpos = PW'(77); mouse_ypos = PW'(100);
        step();
        check("restart_busy", busy, 0);
        check("restart_y_no_tick", ypos, tq[kr-1]);
        check("restart_x_held", xpos, 15);
        step();
        check("restart_track_y", ypos, 100);
        check("restart_track_x", xpos, 77);

        // Held button: a single release, then asynchronous reset mid-fall.
        mouse_left = 1'b0; step();
        track(300, 100);
        mouse_left = 1'b1;
        nb = 0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (busy !== 1'b1) nb++;
        end
        check("held_single_release", nb, 0);
        check("held_x_frozen", xpos, 300);
        rst = 1'b1;
        #1;
        check("async_rst_x", xpos, 0);
        check("async_rst_y", ypos, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_rest", at_rest, 0);
        step();
        rst = 1'b0;
        track(123, 45);

        // Randomized drops with the mouse moving during motion.
        for (int t = 0; t < 5; t++)
            run_fall(int'($urandom_range(0, 799)), int'($urandom_range(0, 700)), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
